// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator and checker.
// Keeping the default polynomial here stops the two ends from drifting apart.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 4;
    localparam logic [DefaultWidth-1:0] DefaultTaps = 4'b1100;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream and status signals between a PRBS source/monitor and the checker.
interface lfsr_checker_if;
    import lfsr_pkg::*;

    logic       din;
    logic       din_valid;
    logic       clr_cnt;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    state_e     state;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err, err_count, state
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err, err_count, state
    );

endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: predicted feedback bit and the register advanced by it.
module lfsr_step #(
    parameter int unsigned WIDTH = lfsr_pkg::DefaultWidth
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] taps,
    output logic             p,
    output logic [WIDTH-1:0] shifted
);

    assign p       = ^(r & taps);
    assign shifted = {r[WIDTH-2:0], p};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: seeds from the line, verifies a run of
// predictions, then counts bit errors while free-running on its own sequence.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH    = DefaultWidth,
    parameter logic [WIDTH-1:0]  TAPS     = DefaultTaps,
    parameter int unsigned       LOCK_CNT = 8,
    parameter int unsigned       LOSS_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lfsr_checker_if.slave bus
);

    localparam int unsigned       FillW   = $clog2(WIDTH + 1);
    localparam logic [FillW-1:0]  FillMax = FillW'(WIDTH);
    localparam logic [7:0]        LockMax = 8'(LOCK_CNT);
    localparam logic [7:0]        LossMax = 8'(LOSS_CNT);

    state_e           state_q;
    logic [WIDTH-1:0] r_q;
    logic [FillW-1:0] fill_q;
    logic [7:0]       run_q;
    logic             locked_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;

    logic             pred;
    logic [WIDTH-1:0] r_pred;
    logic             r_nz;
    logic [7:0]       run_inc;

    lfsr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r_q),
        .taps   (TAPS),
        .p      (pred),
        .shifted(r_pred)
    );

    assign r_nz    = |r_q;
    assign run_inc = run_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            r_q       <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.din_valid) begin
                unique case (state_q)
                    SEARCH: begin
                        r_q <= {r_q[WIDTH-2:0], bus.din};
                        if (fill_q != FillMax) fill_q <= fill_q + 1'b1;
                        // First prediction only once the register holds a full, non-zero seed.
                        if (fill_q == FillMax && r_nz && bus.din == pred) begin
                            if (LockMax == 8'd1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                state_q <= VERIFY;
                                run_q   <= 8'd1;
                            end
                        end
                    end
                    VERIFY: begin
                        r_q <= {r_q[WIDTH-2:0], bus.din};
                        if (!r_nz || bus.din != pred) begin
                            state_q <= SEARCH;
                            run_q   <= '0;
                        end else if (run_inc == LockMax) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            run_q    <= '0;
                        end else begin
                            run_q <= run_inc;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so line errors cannot corrupt the reference.
                        r_q <= r_pred;
                        if (!r_nz) begin
                            state_q  <= SEARCH;
                            locked_q <= 1'b0;
                            fill_q   <= '0;
                            run_q    <= '0;
                        end else if (bus.din != pred) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                            if (run_inc == LossMax) begin
                                state_q  <= SEARCH;
                                locked_q <= 1'b0;
                                fill_q   <= '0;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                    end
                endcase
            end
            if (bus.clr_cnt) err_cnt_q <= '0;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a queue-based reference model.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int W = 4;
    localparam logic [3:0] T = 4'b1100;
    localparam int LOCK = 8;
    localparam int LOSS = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_checker_if bus ();

    lfsr_checker #(
        .WIDTH   (W),
        .TAPS    (T),
        .LOCK_CNT(LOCK),
        .LOSS_CNT(LOSS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Stimulus source: the generator emits its feedback bit and shifts it in.
    bit [3:0] gen;
    function automatic bit gen_next();
        bit b;
        b   = ^(gen & T);
        gen = {gen[2:0], b};
        return b;
    endfunction

    // Reference model: history of the local sequence, newest bit at the back.
    bit m_hist[$];
    int m_mode;  // 0 search, 1 verify, 2 locked
    int m_fill, m_run, m_cnt;
    bit m_err;

    function automatic bit m_pred();
        bit p = 1'b0;
        for (int i = 0; i < W; i++)
            if (T[i]) p ^= m_hist[m_hist.size() - 1 - i];
        return p;
    endfunction

    function automatic bit m_zero();
        for (int i = 0; i < m_hist.size(); i++) if (m_hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_run = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic model_update(input bit v, input bit d, input bit c);
        bit p, z;
        m_err = 1'b0;
        if (v) begin
            p = m_pred();
            z = m_zero();
            case (m_mode)
                0: begin
                    if (m_fill == W && !z && d == p) begin
                        m_run  = 1;
                        m_mode = (m_run >= LOCK) ? 2 : 1;
                        if (m_mode == 2) m_run = 0;
                    end
                    m_fill = (m_fill < W) ? m_fill + 1 : W;
                    m_push(d);
                end
                1: begin
                    m_push(d);
                    if (z || d != p) begin
                        m_mode = 0; m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
                    end
                end
                default: begin
                    m_push(p);
                    if (z) begin
                        m_mode = 0; m_fill = 0; m_run = 0;
                    end else if (d != p) begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                        m_run++;
                        if (m_run == LOSS) begin m_mode = 0; m_fill = 0; m_run = 0; end
                    end else begin
                        m_run = 0;
                    end
                end
            endcase
        end
        if (c) m_cnt = 0;
    endtask

    // Apply one cycle of inputs, then advance the model to the post-edge state.
    task automatic step(input bit v, input bit d, input bit c);
        bus.din_valid = v;
        bus.din       = d;
        bus.clr_cnt   = c;
        @(posedge clk);
        #1;
        model_update(v, d, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_cnt = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks += 4;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.err_count); end
        if (bus.state !== SEARCH) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        int errs = 0;
        gen = 4'b0001;
        for (int k = 1; k <= 200; k++) begin
            step(1'b1, gen_next(), 1'b0);
            if (bus.err === 1'b1) errs++;
            n_checks++;
            if ({bus.locked, bus.err, bus.err_count, bus.state} !==
                {m_mode == 2, m_err, 8'(m_cnt), 2'(m_mode)}) begin
                n_fail++;
                $display("FAIL clean_model bit %0d: got l%b e%b c%0d s%0d want l%b e%b c%0d s%0d", k,
                         bus.locked, bus.err, bus.err_count, bus.state, m_mode == 2, m_err, m_cnt, m_mode);
            end
            if (k == 11 || k == 12) begin
                n_checks++;
                if (bus.locked !== (k == 12)) begin
                    n_fail++;
                    $display("FAIL clean_lock_time bit %0d: got %b want %b", k, bus.locked, k == 12);
                end
            end
        end
        n_checks += 2;
        if (errs != 0) begin n_fail++; $display("FAIL clean_err_pulses: got %0d want 0", errs); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL clean_cnt: got %0d want 0", bus.err_count); end
    endtask

    task automatic test_single_error();
        int errs = 0;
        step(1'b1, ~gen_next(), 1'b0);
        n_checks += 3;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL single_err: got %b want 1", bus.err); end
        if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", bus.err_count); end
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %b want 1", bus.locked); end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, gen_next(), 1'b0);
            if (bus.err === 1'b1 || bus.locked !== 1'b1) errs++;
        end
        n_checks += 2;
        if (errs != 0) begin n_fail++; $display("FAIL single_cascade: got %0d bad cycles want 0", errs); end
        if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL single_cnt_hold: got %0d want 1", bus.err_count); end
    endtask

    task automatic test_burst();
        step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, ~gen_next(), 1'b0);
            n_checks += 2;
            if (bus.err !== 1'b1) begin n_fail++; $display("FAIL burst_err %0d: got %b want 1", k, bus.err); end
            if (bus.locked !== (k < 4)) begin
                n_fail++;
                $display("FAIL burst_locked %0d: got %b want %b", k, bus.locked, k < 4);
            end
        end
        n_checks++;
        if (bus.err_count !== 8'd4) begin n_fail++; $display("FAIL burst_cnt: got %0d want 4", bus.err_count); end
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, gen_next(), 1'b0);
            n_checks++;
            if ({bus.locked, bus.err, bus.err_count, bus.state} !==
                {m_mode == 2, m_err, 8'(m_cnt), 2'(m_mode)} || bus.locked !== (k == 12)) begin
                n_fail++;
                $display("FAIL burst_relock bit %0d: got l%b s%0d c%0d want l%b s%0d c%0d", k,
                         bus.locked, bus.state, bus.err_count, k == 12, m_mode, m_cnt);
            end
        end
    endtask

    task automatic test_zero_stream();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.state !== SEARCH || bus.locked !== 1'b0 || bus.err_count !== 8'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL zero_stream: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_gaps_and_saturation();
        int  nvalid = 0;
        int  cyc = 0;
        int  inj = 0;
        bit  v, bad_flag;
        do_reset();
        gen = 4'b0001;
        while (nvalid < 12 && cyc < 1000) begin
            v = 1'($urandom_range(0, 1));
            step(v, v ? gen_next() : 1'($urandom), 1'b0);
            cyc++;
            if (v) nvalid++;
            if (v && nvalid >= 11) begin
                n_checks++;
                if (bus.locked !== (nvalid == 12)) begin
                    n_fail++;
                    $display("FAIL gaps_lock valid %0d: got %b want %b", nvalid, bus.locked, nvalid == 12);
                end
            end
        end
        n_checks++;
        if (nvalid != 12) begin n_fail++; $display("FAIL gaps_timeout: got %0d valid want 12", nvalid); end
        // Alternate corrupted and clean valid bits so lock is never lost.
        bad_flag = 1'b0;
        cyc = 0;
        while (inj < 300 && cyc < 5000) begin
            v = 1'($urandom_range(0, 1));
            cyc++;
            if (!v) step(1'b0, 1'($urandom), 1'b0);
            else begin
                step(1'b1, ~gen_next(), 1'b0);
                inj++;
                if ({bus.locked, bus.err, bus.err_count} !== {m_mode == 2, m_err, 8'(m_cnt)}) bad_flag = 1'b1;
                step(1'b1, gen_next(), 1'b0);
                if ({bus.locked, bus.err, bus.err_count} !== {m_mode == 2, m_err, 8'(m_cnt)}) bad_flag = 1'b1;
            end
        end
        n_checks += 3;
        if (bad_flag) begin n_fail++; $display("FAIL sat_model: got divergence want none"); end
        if (inj != 300) begin n_fail++; $display("FAIL sat_timeout: got %0d injected want 300", inj); end
        if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", bus.err_count); end
        step(1'b1, ~gen_next(), 1'b1);
        n_checks += 2;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL clr_err: got %b want 1", bus.err); end
        if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", bus.err_count); end
    endtask

    task automatic test_reset_locked();
        step(1'b1, ~gen_next(), 1'b0);
        n_checks++;
        if (bus.err_count !== 8'd1 || bus.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset: got l%b c%0d want l1 c1", bus.locked, bus.err_count);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.locked, bus.err_count, bus.state} !== {1'b0, 8'd0, SEARCH}) begin
            n_fail++;
            $display("FAIL midreset: got l%b c%0d s%0d want l0 c0 s0", bus.locked, bus.err_count, bus.state);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, gen_next(), 1'b0);
            n_checks++;
            if ({bus.locked, bus.err, bus.err_count, bus.state} !==
                {m_mode == 2, m_err, 8'(m_cnt), 2'(m_mode)} || bus.locked !== (k == 12)) begin
                n_fail++;
                $display("FAIL reset_relock bit %0d: got l%b s%0d want l%b s%0d", k,
                         bus.locked, bus.state, k == 12, m_mode);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst();
        test_zero_stream();
        test_gaps_and_saturation();
        test_reset_locked();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker that receives the bit stream produced by the team's LFSR generator and measures its integrity. It self-synchronises by seeding its own LFSR from the incoming bits. It then predicts each following bit and declares lock after a run of correct predictions. Once locked it counts bit errors and drops lock on sustained mismatch. It sits behind the pin-level top wrapper on the receive side of a loopback or board-to-board link test.

## Interface
- `WIDTH`, 4: LFSR length in bits; legal range 3..16.
- `TAPS`, 4'b1100: feedback mask, `WIDTH` bits; feedback = XOR of (shift register AND `TAPS`).
- `LOCK_CNT`, 8: consecutive correct predictions needed to lock; 1..255.
- `LOSS_CNT`, 4: consecutive mispredictions that drop lock; 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  received serial bit.
- `din_valid`  in  1  `din` is sampled only on cycles where this is high.
- `clr_cnt`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  checker is in LOCKED state.
- `err`  out  1  one-cycle pulse for a mispredicted bit while LOCKED.
- `err_count`  out  8  saturating error count.
- `state`  out  2  current FSM state, for debug pins.

## Operation
- Reset values: `locked`=0, `err`=0, `err_count`=0, `state`=SEARCH, shift register `r`=0, fill counter=0, run counter=0.
- Shift convention: `r <= {r[WIDTH-2:0], bit}`. Predicted bit `p` = ^(`r` & `TAPS`).
- On cycles where `din_valid`=0, nothing changes and `err`=0.
- SEARCH: every valid bit shifts `din` into `r`; the fill counter increments and saturates at `WIDTH`.
  - At the first valid bit with fill=`WIDTH` and `r`≠0, compare `din` with `p`:
    - match: run=1, go VERIFY;
    - mismatch: stay in SEARCH.
  - `din` is shifted in either way.
- VERIFY: valid bit shifts `din` into `r`.
  - match: run+1; when run reaches `LOCK_CNT`, go LOCKED with run=0.
  - mismatch: run=0, go SEARCH; fill stays at `WIDTH`, so prediction resumes on the next bit.
- All-zero guard: if `r`=0 in any state, force SEARCH. An all-zero input never locks.
- LOCKED: valid bit shifts `p` (not `din`) into `r`, so line errors do not corrupt the local sequence.
  - mismatch: `err`=1, `err_count`+1 (saturates at 255), run+1; when run reaches `LOSS_CNT`, go SEARCH with fill=0, run=0.
  - match: run=0.
- `clr_cnt`=1 sets `err_count` to 0 in the next cycle and has priority over an increment in the same cycle. It affects nothing else.
- `err_count` holds across loss of lock; only reset or `clr_cnt` clears it.

## Timing
- Every output is a register; there is no combinational path from input to output.
- `err` goes high in the cycle after the mispredicted valid sample and lasts exactly one cycle.
- `locked` rises in the cycle after the `LOCK_CNT`-th consecutive match.
- Minimum time to lock from reset is `WIDTH`+`LOCK_CNT` valid bits; the default is 12, so `locked` is high in the cycle after the 12th valid bit.
- `locked` falls in the cycle after the `LOSS_CNT`-th consecutive mismatch.
- Asserting `rst_n` low mid-stream returns every register to its reset value immediately. Relock then needs a full `WIDTH`+`LOCK_CNT` valid bits.
- Full throughput: one bit per cycle, with no restriction on back-to-back `din_valid`.

## Structure
- Package `lfsr_pkg`:
  - state enum: SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2;
  - default `WIDTH` and `TAPS` constants, shared with the generator so the polynomials cannot diverge.
- Sub-module `lfsr_step`: combinational; inputs `r` and `TAPS`, outputs `p` and the shifted value. The generator can reuse it.
- Top-level pin mapping (`ui_in`/`uo_out`) lives in a separate wrapper and is not part of this block.

## Test plan
- Error-free stream from the generator seeded 4'b0001, `din_valid`=1 every cycle -> `locked`=1 in the cycle after the 12th bit, `err` never asserts, `err_count`=0 after 200 bits.
- Locked, then invert one isolated bit -> a single `err` pulse, `err_count`=1, `locked` stays 1, the following bits match with no error cascade.
- Locked, then invert 4 consecutive bits -> 4 `err` pulses, `err_count`=4, `locked`=0 in the cycle after the 4th, relock after 12 further clean bits.
- Constant `din`=0 for 100 valid bits -> `state` stays SEARCH, `locked`=0, `err_count`=0.
- Random `din_valid` gaps (~50% duty) over a clean stream -> lock after exactly 12 valid bits. Then 300 injected errors -> `err_count` saturates at 255. Then `clr_cnt` pulsed together with an error -> `err_count`=0.
- `rst_n` pulsed low while LOCKED -> `locked`=0, `err_count`=0, `state`=SEARCH immediately, relock after 12 valid bits.
